pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage RV32I pipeline. It drives stall and flush enables for the F/D, D/E, E/M and M/W pipeline registers, and forwarding selects for the Execute-stage ALU operands. It sequences multi-cycle data-memory accesses through a req/ack wait FSM with a timeout. It sits beside the datapath and only consumes register addresses and control bits that the stage registers already carry.

Parameters:
REG_ADDR_W, 5, register-file address width
MEM_TIMEOUT, 64, maximum number of wait cycles for a memory ack before an error is raised (must be ≥1)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
Rs1D  in  REG_ADDR_W  source 1 of the instruction in Decode
Rs2D  in  REG_ADDR_W  source 2 of the instruction in Decode
Rs1E  in  REG_ADDR_W  source 1 of the instruction in Execute
Rs2E  in  REG_ADDR_W  source 2 of the instruction in Execute
RdE  in  REG_ADDR_W  destination of the instruction in Execute
ResultSrcE  in  2  result select in Execute; 2'b01 = load
PCSrcE  in  1  taken branch or jump redirect resolved in Execute
RdM  in  REG_ADDR_W  destination of the instruction in Memory
RegWriteM  in  1  Memory-stage write enable
RdW  in  REG_ADDR_W  destination of the instruction in Writeback
RegWriteW  in  1  Writeback-stage write enable
MemReqM  in  1  Memory stage is issuing a data-memory access
MemAckM  in  1  data memory completes the access this cycle
ForwardAE  out  2  ALU operand A select: 00 = register file, 01 = Writeback result, 10 = ALUResultM
ForwardBE  out  2  ALU operand B select, same encoding
StallF  out  1  hold the PC
StallD  out  1  hold the F/D register
FlushD  out  1  clear the F/D register
StallE  out  1  hold the D/E register
FlushE  out  1  clear the D/E register (insert a bubble)
StallM  out  1  hold the E/M register
FlushW  out  1  clear the M/W register
MemErr  out  1  sticky memory-timeout error

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. All state resets on the rising edge of clk while rst=1.
- Outputs while rst=1:
  - FlushD=1, FlushE=1, FlushW=1.
  - All stalls are 0; ForwardAE/BE are 00; MemErr is 0.
  - FSM state is RUN; wait counter is 0.
- Forwarding (combinational, zero latency):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else ForwardAE=00.
  - ForwardBE uses the same rules with Rs2E. The Memory stage has priority over Writeback.
- Terms used below:
  - lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - memStall = MemReqM && !MemAckM, or state==MEM_ERR.
- Priority, highest first:
  1. memStall: StallF=StallD=StallE=StallM=1, FlushW=1. FlushD=FlushE=0. lwStall and PCSrcE are ignored; they remain asserted and are serviced after the stall releases.
  2. PCSrcE: FlushD=1, FlushE=1, no stalls. This suppresses lwStall, because the dependent instruction in Decode is on the wrong path.
  3. lwStall: StallF=1, StallD=1, FlushE=1. The bubble lasts exactly 1 cycle.
  4. Otherwise: all outputs are 0.
- FSM:
  - RUN → MEM_WAIT when MemReqM && !MemAckM. The counter loads 1.
  - MEM_WAIT, MemAckM=1 → RUN. Stall deasserts in the ack cycle and the pipeline advances on that edge. The counter clears.
  - MEM_WAIT, no ack, counter < MEM_TIMEOUT → counter increments.
  - MEM_WAIT, no ack, counter == MEM_TIMEOUT → MEM_ERR. MemErr=1 from the next cycle.
  - MEM_ERR: terminal. The pipeline stays frozen and MemErr stays 1 until rst.
  - A MemReqM/MemAckM pair arriving in the same RUN cycle causes no stall and no state change.
- Counter width: $clog2(MEM_TIMEOUT+1) bits. It never wraps.
- Reset mid-wait: on the rst edge the FSM returns to RUN and the counter clears. A subsequently outstanding MemReqM re-enters MEM_WAIT normally.

Optional Feature:
HAZARD_PERF_EN
- Defined:
  - Adds outputs StallCount[31:0] and FlushCount[31:0], both reset to 0.
  - StallCount increments on every cycle with StallF=1.
  - FlushCount increments on every cycle with FlushE=1 caused by PCSrcE or lwStall. The reset-driven flush does not count.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and registers are absent and all other behaviour is identical.

Test Plan:
- Forwarding: RegWriteM=1, RdM=5, Rs1E=5 while also RegWriteW=1, RdW=5 → ForwardAE=10. Set RdM=0 → ForwardAE=01. Rs2E=0 with RdW=0 → ForwardBE=00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for exactly 1 cycle. The next cycle with ResultSrcE=00 → all stalls and flushes are 0.
- Branch overrides load-use: PCSrcE=1 with an active lwStall → FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemAckM=0 for 3 cycles, then MemAckM=1 → StallF/D/E/M=1 and FlushW=1 for 3 cycles; 0 in the ack cycle; FSM returns to RUN.
- Timeout: MEM_TIMEOUT=4, MemReqM=1, never ack → MemErr=1 from cycle 5 onward with the pipeline frozen. Assert rst for 1 cycle → MemErr=0, FSM in RUN, FlushD/E/W=1 during reset.
- With HAZARD_PERF_EN defined: 2 load-use stalls plus 1 branch → StallCount=2, FlushCount=3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
// Bundles the signals exchanged between the RV32I datapath and the hazard
// controller.
//   master : datapath side. It drives the register addresses, control bits and
//            memory handshake. It receives the forwarding selects,
//            stall/flush enables and MemErr.
//   slave  : hazard controller side, with the opposite directions.
// Optional macro HAZARD_PERF_EN adds the StallCount/FlushCount outputs.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] Rs1D;
  logic [REG_ADDR_W-1:0] Rs2D;
  logic [REG_ADDR_W-1:0] Rs1E;
  logic [REG_ADDR_W-1:0] Rs2E;
  logic [REG_ADDR_W-1:0] RdE;
  logic [1:0]            ResultSrcE;
  logic                  PCSrcE;
  logic [REG_ADDR_W-1:0] RdM;
  logic                  RegWriteM;
  logic [REG_ADDR_W-1:0] RdW;
  logic                  RegWriteW;
  logic                  MemReqM;
  logic                  MemAckM;

  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic                  StallF;
  logic                  StallD;
  logic                  FlushD;
  logic                  StallE;
  logic                  FlushE;
  logic                  StallM;
  logic                  FlushW;
  logic                  MemErr;
`ifdef HAZARD_PERF_EN
  logic [31:0]           StallCount;
  logic [31:0]           FlushCount;
`endif

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemAckM,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, StallE, FlushE,
           StallM, FlushW, MemErr
`ifdef HAZARD_PERF_EN
    , input StallCount, FlushCount
`endif
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemAckM,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, StallE, FlushE,
           StallM, FlushW, MemErr
`ifdef HAZARD_PERF_EN
    , output StallCount, FlushCount
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central hazard controller for the 5-stage RV32I pipeline. It provides:
//   - Execute-stage operand forwarding selects. Memory has priority over Writeback.
//   - Load-use stall with a one-cycle bubble.
//   - Branch/jump flush.
//   - A data-memory wait FSM with a timeout and a sticky error.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   hz  : pipeline_hazard_ctrl_if.slave, which carries all datapath inputs and
//         the hazard outputs
// Optional macro HAZARD_PERF_EN adds the saturating StallCount/FlushCount.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | no outstanding memory access beyond the current cycle
// MEM_WAIT | access outstanding; wait_cnt counts cycles spent waiting
// MEM_ERR  | ack never arrived; pipeline frozen until rst
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 64
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic       lw_stall;
  logic       mem_stall;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w;
  logic       mem_err;

  // Forwarding
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (hz.RegWriteM && hz.RdM != REG_ADDR_W'(0) && hz.RdM == hz.Rs1E)
        fwd_a = 2'b10;
      else if (hz.RegWriteW && hz.RdW != REG_ADDR_W'(0) && hz.RdW == hz.Rs1E)
        fwd_a = 2'b01;
      if (hz.RegWriteM && hz.RdM != REG_ADDR_W'(0) && hz.RdM == hz.Rs2E)
        fwd_b = 2'b10;
      else if (hz.RegWriteW && hz.RdW != REG_ADDR_W'(0) && hz.RdW == hz.Rs2E)
        fwd_b = 2'b01;
    end
  end

  assign lw_stall  = (hz.ResultSrcE == 2'b01) && (hz.RdE != REG_ADDR_W'(0)) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign mem_stall = (hz.MemReqM && !hz.MemAckM) || (state_q == MEM_ERR);

  // Stall/flush priority: reset, memory, redirect, load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    stall_e = 1'b0;
    flush_e = 1'b0;
    stall_m = 1'b0;
    flush_w = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // The stored state only updates on the edge, so MemErr is gated so that it
  // reads 0 for the whole reset cycle.
  assign mem_err = !rst && (state_q == MEM_ERR);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (hz.MemReqM && !hz.MemAckM) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.MemAckM) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
          state_d = MEM_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      MEM_ERR: begin
        state_d = MEM_ERR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic        hazard_flush;

  // FlushE raised by a redirect or a load-use hazard. Reset-driven and
  // memory-stall cycles are excluded.
  assign hazard_flush = !rst && !mem_stall && (hz.PCSrcE || lw_stall);

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_f && stall_count_q != 32'hFFFF_FFFF)
      stall_count_d = stall_count_q + 32'd1;
    if (hazard_flush && flush_count_q != 32'hFFFF_FFFF)
      flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign hz.StallCount = stall_count_q;
  assign hz.FlushCount = flush_count_q;
`endif

  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.FlushD    = flush_d;
  assign hz.StallE    = stall_e;
  assign hz.FlushE    = flush_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushW    = flush_w;
  assign hz.MemErr    = mem_err;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Directed-vector bench for pipeline_hazard_ctrl, built with MEM_TIMEOUT=4.
// Inputs change 1 ns after a rising edge. Outputs are sampled 2 ns after the
// edge, well before the next edge.
module tb_pipeline_hazard_ctrl;
  logic clk;
  logic rst;
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) hif ();

  pipeline_hazard_ctrl #(
    .REG_ADDR_W (5),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    hif.Rs1D = '0; hif.Rs2D = '0; hif.Rs1E = '0; hif.Rs2E = '0; hif.RdE = '0;
    hif.ResultSrcE = 2'b00; hif.PCSrcE = 1'b0;
    hif.RdM = '0; hif.RegWriteM = 1'b0; hif.RdW = '0; hif.RegWriteW = 1'b0;
    hif.MemReqM = 1'b0; hif.MemAckM = 1'b0;
  endtask

  // Packs {StallF,StallD,FlushD,StallE,FlushE,StallM,FlushW}
  function automatic logic [6:0] ctl();
    return {hif.StallF, hif.StallD, hif.FlushD, hif.StallE, hif.FlushE, hif.StallM, hif.FlushW};
  endfunction

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    settle();
    check("rst_ctl",    32'(ctl()),       32'b0010101);
    check("rst_fwd_a",  32'(hif.ForwardAE), 32'd0);
    check("rst_memerr", 32'(hif.MemErr),  32'd0);
    tick();
    rst = 1'b0;
    settle();
    check("idle_ctl", 32'(ctl()), 32'b0000000);

    // Forwarding: Memory beats Writeback, x0 never forwards
    hif.RegWriteM = 1'b1; hif.RdM = 5'd5; hif.Rs1E = 5'd5;
    hif.RegWriteW = 1'b1; hif.RdW = 5'd5;
    settle();
    check("fwd_a_mem", 32'(hif.ForwardAE), 32'd2);
    hif.RdM = 5'd0;
    settle();
    check("fwd_a_wb", 32'(hif.ForwardAE), 32'd1);
    hif.Rs2E = 5'd0; hif.RdW = 5'd0;
    settle();
    check("fwd_b_x0", 32'(hif.ForwardBE), 32'd0);
    hif.Rs2E = 5'd9; hif.RdW = 5'd9; hif.RdM = 5'd9; hif.RegWriteM = 1'b0;
    settle();
    check("fwd_b_wb_only", 32'(hif.ForwardBE), 32'd1);
    hif.RegWriteM = 1'b1;
    settle();
    check("fwd_b_mem", 32'(hif.ForwardBE), 32'd2);
    clear_inputs();

    // Load-use
    tick();
    hif.ResultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
    settle();
    check("lw_stall", 32'(ctl()), 32'b1100100);
    tick();
    hif.ResultSrcE = 2'b00;
    settle();
    check("lw_after", 32'(ctl()), 32'b0000000);
    hif.ResultSrcE = 2'b01; hif.RdE = 5'd0; hif.Rs1D = 5'd0; hif.Rs2D = 5'd0;
    settle();
    check("lw_rd_x0", 32'(ctl()), 32'b0000000);

    // Branch overrides load-use
    hif.RdE = 5'd7; hif.Rs1D = 5'd7; hif.PCSrcE = 1'b1;
    settle();
    check("branch_over_lw", 32'(ctl()), 32'b0010100);
    clear_inputs();

    // Same-cycle req/ack: no stall
    tick();
    hif.MemReqM = 1'b1; hif.MemAckM = 1'b1;
    settle();
    check("req_ack_same", 32'(ctl()), 32'b0000000);

    // Memory wait of 3 cycles, then ack. A redirect during the wait is ignored.
    tick();
    hif.MemAckM = 1'b0;
    hif.PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("mem_wait_%0d", i), 32'(ctl()), 32'b1101011);
      tick();
    end
    hif.MemAckM = 1'b1;
    settle();
    check("mem_ack_ctl", 32'(ctl()), 32'b0010100);
    tick();
    clear_inputs();
    settle();
    check("mem_after", 32'(ctl()), 32'b0000000);
    check("mem_after_err", 32'(hif.MemErr), 32'd0);

    // Ack exactly at the timeout boundary returns to RUN without an error
    hif.MemReqM = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    hif.MemAckM = 1'b1;
    settle();
    check("ack_at_limit", 32'(hif.StallF), 32'd0);
    tick();
    clear_inputs();
    settle();
    check("ack_at_limit_err", 32'(hif.MemErr), 32'd0);
    tick();
    check("ack_at_limit_err2", 32'(hif.MemErr), 32'd0);

    // Timeout: MemErr rises on cycle 5 of an unanswered request
    hif.MemReqM = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("to_noerr_%0d", i), 32'(hif.MemErr), 32'd0);
      tick();
    end
    settle();
    check("to_err", 32'(hif.MemErr), 32'd1);
    hif.MemReqM = 1'b0;
    hif.PCSrcE  = 1'b1;
    settle();
    check("to_frozen", 32'(ctl()), 32'b1101011);
    tick();
    check("to_sticky", 32'(hif.MemErr), 32'd1);
    clear_inputs();
    rst = 1'b1;
    settle();
    check("to_rst_ctl", 32'(ctl()), 32'b0010101);
    check("to_rst_err", 32'(hif.MemErr), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    check("to_run_ctl", 32'(ctl()), 32'b0000000);
    check("to_run_err", 32'(hif.MemErr), 32'd0);

    // Reset mid-wait clears the counter; a new wait gets the full budget
    hif.MemReqM = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("rw_noerr_%0d", i), 32'(hif.MemErr), 32'd0);
      tick();
    end
    settle();
    check("rw_err", 32'(hif.MemErr), 32'd1);
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;

`ifdef HAZARD_PERF_EN
    // Two load-use stalls and one branch
    hif.ResultSrcE = 2'b01; hif.RdE = 5'd3; hif.Rs1D = 5'd3;
    tick();
    tick();
    hif.ResultSrcE = 2'b00; hif.PCSrcE = 1'b1;
    tick();
    clear_inputs();
    settle();
    check("perf_stall", hif.StallCount, 32'd2);
    check("perf_flush", hif.FlushCount, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
